// File: rtl/gcd_host_ctrl.sv
// Host-side sequencer for the core's GCD register interface: accepts operand requests,
// drives gcd_a/gcd_b/calc_start, and returns the x10 write-back result or a timeout error.
module gcd_host_ctrl #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_err,
    output logic [DATA_W-1:0] gcd_a,
    output logic [DATA_W-1:0] gcd_b,
    output logic              calc_start,
    input  logic              result_wr,
    input  logic [DATA_W-1:0] result_data,
    output logic              busy
);

    localparam int unsigned    CntW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] TermCnt = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StResp} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] gcd_a_q, gcd_a_d;
    logic [DATA_W-1:0] gcd_b_q, gcd_b_d;
    logic              calc_start_q, calc_start_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_err_q, rsp_err_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            gcd_a_q      <= '0;
            gcd_b_q      <= '0;
            calc_start_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            gcd_a_q      <= gcd_a_d;
            gcd_b_q      <= gcd_b_d;
            calc_start_q <= calc_start_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        gcd_a_d      = gcd_a_q;
        gcd_b_d      = gcd_b_q;
        calc_start_d = calc_start_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_a == '0 || req_b == '0) begin
                        // Trivial job: answer directly, core untouched.
                        state_d      = StResp;
                        rsp_valid_d  = 1'b1;
                        rsp_result_d = req_a | req_b;
                        rsp_err_d    = 1'b0;
                    end else begin
                        state_d      = StRun;
                        gcd_a_d      = req_a;
                        gcd_b_d      = req_b;
                        calc_start_d = 1'b1;
                        cnt_d        = '0;
                    end
                end
            end
            StRun: begin
                // A write-back on the terminal-count cycle still counts as success.
                if (result_wr) begin
                    state_d      = StResp;
                    calc_start_d = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = result_data;
                    rsp_err_d    = 1'b0;
                end else if (cnt_q == TermCnt) begin
                    state_d      = StResp;
                    calc_start_d = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = '0;
                    rsp_err_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign req_ready  = rst_n && (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign gcd_a      = gcd_a_q;
    assign gcd_b      = gcd_b_q;
    assign calc_start = calc_start_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_gcd_host_ctrl.sv
// Bench for gcd_host_ctrl: directed vector table, hand sequences for reset and stray writes,
// and random jobs checked against a transaction-level reference model.
module tb_gcd_host_ctrl;

    localparam int unsigned W   = 32;
    localparam int unsigned TM  = 32;
    localparam int unsigned T8  = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sel = 1'b0;
    logic         req_valid = 1'b0, rsp_ready = 1'b0, result_wr = 1'b0;
    logic [W-1:0] req_a = '0, req_b = '0, result_data = '0;

    logic         m_req_ready, m_rsp_valid, m_rsp_err, m_calc, m_busy;
    logic [W-1:0] m_rsp_result, m_gcd_a, m_gcd_b;
    logic         e_req_ready, e_rsp_valid, e_rsp_err, e_calc, e_busy;
    logic [W-1:0] e_rsp_result, e_gcd_a, e_gcd_b;

    logic         v_req_ready, v_rsp_valid, v_rsp_err, v_calc, v_busy;
    logic [W-1:0] v_rsp_result, v_gcd_a, v_gcd_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gcd_host_ctrl #(.DATA_W(W), .TIMEOUT_CYCLES(TM)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid && !sel), .req_ready(m_req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(m_rsp_valid), .rsp_ready(rsp_ready && !sel),
        .rsp_result(m_rsp_result), .rsp_err(m_rsp_err),
        .gcd_a(m_gcd_a), .gcd_b(m_gcd_b), .calc_start(m_calc),
        .result_wr(result_wr && !sel), .result_data(result_data), .busy(m_busy)
    );

    gcd_host_ctrl #(.DATA_W(W), .TIMEOUT_CYCLES(T8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid && sel), .req_ready(e_req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(e_rsp_valid), .rsp_ready(rsp_ready && sel),
        .rsp_result(e_rsp_result), .rsp_err(e_rsp_err),
        .gcd_a(e_gcd_a), .gcd_b(e_gcd_b), .calc_start(e_calc),
        .result_wr(result_wr && sel), .result_data(result_data), .busy(e_busy)
    );

    assign v_req_ready  = sel ? e_req_ready  : m_req_ready;
    assign v_rsp_valid  = sel ? e_rsp_valid  : m_rsp_valid;
    assign v_rsp_err    = sel ? e_rsp_err    : m_rsp_err;
    assign v_calc       = sel ? e_calc       : m_calc;
    assign v_busy       = sel ? e_busy       : m_busy;
    assign v_rsp_result = sel ? e_rsp_result : m_rsp_result;
    assign v_gcd_a      = sel ? e_gcd_a      : m_gcd_a;
    assign v_gcd_b      = sel ? e_gcd_b      : m_gcd_b;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x = a, y = b, t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Transaction-level model: what response and how many calc_start cycles a job yields.
    function automatic void ref_job(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input int lat, input logic [W-1:0] data, input int tmo,
                                    output logic [W-1:0] res, output logic err,
                                    output int hi);
        if (a == 0 || b == 0) begin
            res = a | b; err = 1'b0; hi = 0;
        end else if (lat >= 1 && lat <= tmo) begin
            res = data; err = 1'b0; hi = lat;
        end else begin
            res = '0; err = 1'b1; hi = tmo;
        end
    endfunction

    // Drives one job; core model pulses result_wr in calc_start cycle 'lat' (0 = never).
    // During 'bp' backpressure cycles, a competing request and a stray write are presented.
    task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                           input logic [W-1:0] data, input int bp,
                           output int hi, output int n, output logic [W-1:0] res,
                           output logic err, output logic [W-1:0] ga, output logic [W-1:0] gb);
        chk("req_ready_before_accept", W'(v_req_ready), W'(1));
        req_valid = 1'b1; req_a = a; req_b = b;
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy_after_accept", W'(v_busy), W'(1));
        hi = 0; n = 0;
        while (!v_rsp_valid && n < 200) begin
            if (v_calc) begin
                hi++;
                if (hi == lat) begin result_wr = 1'b1; result_data = data; end
            end
            @(negedge clk);
            result_wr = 1'b0;
            n++;
        end
        if (n >= 200) chk("rsp_valid_bound", W'(v_rsp_valid), W'(1));
        chk("calc_low_at_rsp", W'(v_calc), W'(0));
        res = v_rsp_result; err = v_rsp_err; ga = v_gcd_a; gb = v_gcd_b;
        for (int i = 0; i < bp; i++) begin
            req_valid = 1'b1; req_a = 3; req_b = 9;
            result_wr = 1'b1; result_data = 99;
            @(negedge clk);
            chk("bp_rsp_valid", W'(v_rsp_valid), W'(1));
            chk("bp_rsp_result", v_rsp_result, res);
            chk("bp_rsp_err", W'(v_rsp_err), W'(err));
            chk("bp_req_ready", W'(v_req_ready), W'(0));
            chk("bp_calc", W'(v_calc), W'(0));
        end
        req_valid = 1'b0; result_wr = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_after_hs", W'(v_rsp_valid), W'(0));
        chk("req_ready_after_hs", W'(v_req_ready), W'(1));
        chk("busy_after_hs", W'(v_busy), W'(0));
    endtask

    typedef struct {
        bit           s;
        logic [W-1:0] a, b;
        int           lat;
        logic [W-1:0] data;
        int           bp;
        logic [W-1:0] exp_res;
        logic         exp_err;
        int           exp_hi;
    } vec_t;

    vec_t         vecs[$];
    logic [W-1:0] last_ga[2];
    logic [W-1:0] last_gb[2];

    task automatic apply(input vec_t v);
        int hi, n;
        logic [W-1:0] res, ga, gb;
        logic err;
        logic [W-1:0] eg_a, eg_b;
        int si;
        si = v.s ? 1 : 0;
        sel = v.s;
        #1;
        run_job(v.a, v.b, v.lat, v.data, v.bp, hi, n, res, err, ga, gb);
        if (v.a != 0 && v.b != 0) begin
            last_ga[si] = v.a; last_gb[si] = v.b;
        end
        eg_a = last_ga[si]; eg_b = last_gb[si];
        chk("rsp_result", res, v.exp_res);
        chk("rsp_err", W'(err), W'(v.exp_err));
        chk("calc_cycles", W'(hi), W'(v.exp_hi));
        chk("rsp_latency", W'(n), W'(v.exp_hi));
        chk("gcd_a", ga, eg_a);
        chk("gcd_b", gb, eg_b);
    endtask

    initial begin
        vec_t v;
        last_ga = '{default: '0};
        last_gb = '{default: '0};

        // Reset with a request pending: nothing accepted, outputs cleared.
        req_valid = 1'b1; req_a = 48; req_b = 18;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_req_ready", W'(m_req_ready), W'(0));
            chk("rst_rsp_valid", W'(m_rsp_valid), W'(0));
            chk("rst_calc", W'(m_calc), W'(0));
            chk("rst_busy", W'(m_busy), W'(0));
            chk("rst_outs", m_gcd_a | m_gcd_b | m_rsp_result | W'(m_rsp_err), '0);
        end
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_req_ready", W'(m_req_ready), W'(1));
        chk("rel_busy", W'(m_busy), W'(0));

        //          s  a   b   lat data bp res err hi
        vecs.push_back('{1'b0, 48, 18, 20, 6, 0, 6, 1'b0, 20});
        vecs.push_back('{1'b0, 0, 35, 0, 0, 0, 35, 1'b0, 0});
        vecs.push_back('{1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 0});
        vecs.push_back('{1'b0, 35, 0, 0, 0, 2, 35, 1'b0, 0});
        vecs.push_back('{1'b0, 12, 8, 1, 4, 5, 4, 1'b0, 1});
        vecs.push_back('{1'b0, 9, 6, 32, 3, 0, 3, 1'b0, 32});
        vecs.push_back('{1'b0, 9, 6, 0, 3, 0, 0, 1'b1, 32});
        vecs.push_back('{1'b1, 7, 5, 0, 1, 0, 0, 1'b1, 8});
        vecs.push_back('{1'b1, 7, 5, 8, 1, 0, 1, 1'b0, 8});
        vecs.push_back('{1'b1, 0, 21, 0, 0, 1, 21, 1'b0, 0});
        foreach (vecs[i]) apply(vecs[i]);
        sel = 1'b0;

        // Random jobs against the reference model.
        for (int i = 0; i < 40; i++) begin
            v.s    = ($urandom_range(0, 3) == 0);
            v.a    = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 5000));
            v.b    = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 5000));
            v.lat  = $urandom_range(0, v.s ? 10 : 40);
            v.data = (v.a != 0 && v.b != 0) ? gcd(v.a, v.b) : '0;
            v.bp   = $urandom_range(0, 3);
            ref_job(v.a, v.b, v.lat, v.data, v.s ? T8 : TM, v.exp_res, v.exp_err, v.exp_hi);
            apply(v);
        end
        sel = 1'b0;
        #1;

        // Reset mid-RUN while the core writes back: job dropped, no response.
        req_valid = 1'b1; req_a = 40; req_b = 30;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrun_calc", W'(m_calc), W'(1));
        rst_n = 1'b0; result_wr = 1'b1; result_data = 10;
        @(negedge clk);
        chk("midrst_calc", W'(m_calc), W'(0));
        chk("midrst_rsp_valid", W'(m_rsp_valid), W'(0));
        chk("midrst_outs", m_gcd_a | m_gcd_b | m_rsp_result | W'(m_rsp_err), '0);
        chk("midrst_req_ready", W'(m_req_ready), W'(0));
        rst_n = 1'b1; result_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", W'(m_rsp_valid), W'(0));
            chk("post_rst_busy", W'(m_busy), W'(0));
        end

        // Stray write-back in IDLE is ignored.
        result_wr = 1'b1; result_data = 99;
        @(negedge clk);
        result_wr = 1'b0;
        @(negedge clk);
        chk("stray_rsp_valid", W'(m_rsp_valid), W'(0));
        chk("stray_rsp_result", m_rsp_result, '0);
        chk("stray_calc", W'(m_calc), W'(0));
        chk("stray_req_ready", W'(m_req_ready), W'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
